// File: rtl/icache_sa_pkg.sv
// Shared defaults and state encoding for the set-associative instruction cache.
package icache_sa_pkg;

    localparam int ICACHE_ADDR_WIDTH = 18;
    localparam int ICACHE_SETS       = 128;
    localparam int ICACHE_WAYS       = 2;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bits, tags and line data, plus tag compare and word read.
module icache_way #(
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 7,
    parameter int IDX_W      = 7,
    parameter int OFF_W      = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [IDX_W-1:0] rd_set,
    input  logic [OFF_W-1:0] rd_off,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             match,
    output logic [31:0]      rd_word,
    input  logic             flush,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_set,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_set,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][LINE_WORDS];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid <= '0;
        end else begin
            if (flush)
                valid <= '0;
            else if (inv_en)
                valid[inv_set] <= 1'b0;
            if (fill_en)
                valid[wr_set] <= wr_valid;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; valid bits alone gate their use.
    always_ff @(posedge clk_in) begin
        if (wr_en)
            data_mem[wr_set][wr_off] <= wr_data;
        if (fill_en)
            tag_mem[wr_set] <= wr_tag;
    end

    assign match   = valid[rd_set] && (tag_mem[rd_set] == rd_tag);
    assign rd_word = data_mem[rd_set][rd_off];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: lookup/bypass muxing, refill FSM and per-set round-robin victims.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int SETS       = ICACHE_SETS,
    parameter int WAYS       = ICACHE_WAYS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        fetch_able,
    input  logic [31:0] input_pc,
    output logic        hit,
    output logic [31:0] hit_ins,
    output logic        need_mem,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_ins,
    input  logic        mem_ins_ready
);

    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(SETS);
    localparam int OFF_W = (OFF > 0) ? OFF : 1;
    localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_WIDTH - OFF - IDX - 2;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);
    localparam logic [RR_W-1:0]  LAST_RR  = RR_W'(WAYS - 1);

    state_t            state, state_next;
    logic              need_mem_next;
    logic [31:0]       mem_addr_next;
    logic [OFF_W-1:0]  cnt, cnt_next;
    logic              flush_pend, flush_pend_next;
    logic [IDX-1:0]    lat_set;
    logic [TAG_W-1:0]  lat_tag;
    logic [RR_W-1:0]   victim;
    logic [SETS-1:0][RR_W-1:0] rr;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX-1:0]    pc_set;
    logic [TAG_W-1:0]  pc_tag;
    logic [31:0]       line_base;

    logic [WAYS-1:0]   way_match;
    logic [31:0]       way_word [WAYS];
    logic [31:0]       array_word;
    logic              array_hit, bypass;
    logic              start_miss, refill_wr, last_word, flush_all, wr_valid;

    // Bits at or above ADDR_WIDTH fall away in the tag cast.
    assign pc_off    = OFF_W'((input_pc >> 2) & 32'(LINE_WORDS - 1));
    assign pc_set    = IDX'(input_pc >> (OFF + 2));
    assign pc_tag    = TAG_W'(input_pc >> (OFF + IDX + 2));
    assign line_base = input_pc & ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

    assign last_word  = (cnt == LAST_CNT);
    assign start_miss = rdy_in && (state == IDLE) && fetch_able && !hit && !flush_in;
    assign refill_wr  = rdy_in && (state == REFILL) && mem_ins_ready;
    assign flush_all  = rdy_in && flush_in;
    assign wr_valid   = !flush_pend && !flush_in;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W),
            .IDX_W      (IDX),
            .OFF_W      (OFF_W)
        ) u_way (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .rd_set   (pc_set),
            .rd_off   (pc_off),
            .rd_tag   (pc_tag),
            .match    (way_match[w]),
            .rd_word  (way_word[w]),
            .flush    (flush_all),
            .inv_en   (start_miss && (rr[pc_set] == RR_W'(w))),
            .inv_set  (pc_set),
            .wr_en    (refill_wr && (victim == RR_W'(w))),
            .wr_set   (lat_set),
            .wr_off   (cnt),
            .wr_data  (mem_ins),
            .fill_en  (refill_wr && last_word && (victim == RR_W'(w))),
            .wr_tag   (lat_tag),
            .wr_valid (wr_valid)
        );
    end

    // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
    always_comb begin
        array_word = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_match[w])
                array_word = array_word | way_word[w];
    end

    assign array_hit = fetch_able && (|way_match);
    assign bypass    = (state == REFILL) && mem_ins_ready && fetch_able && (mem_addr == input_pc);
    assign hit       = array_hit || bypass;
    assign hit_ins   = bypass ? mem_ins : array_word;

    always_comb begin
        state_next      = state;
        need_mem_next   = need_mem;
        mem_addr_next   = mem_addr;
        cnt_next        = cnt;
        flush_pend_next = flush_pend;
        case (state)
            IDLE: begin
                if (fetch_able && !hit && !flush_in) begin
                    state_next    = REFILL;
                    need_mem_next = 1'b1;
                    mem_addr_next = line_base;
                    cnt_next      = '0;
                end
            end
            REFILL: begin
                if (flush_in)
                    flush_pend_next = 1'b1;
                if (mem_ins_ready) begin
                    if (last_word) begin
                        state_next      = IDLE;
                        need_mem_next   = 1'b0;
                        flush_pend_next = 1'b0;
                    end else begin
                        cnt_next      = cnt + 1'b1;
                        mem_addr_next = mem_addr + 32'd4;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            need_mem   <= 1'b0;
            mem_addr   <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else if (rdy_in) begin
            state      <= state_next;
            need_mem   <= need_mem_next;
            mem_addr   <= mem_addr_next;
            cnt        <= cnt_next;
            flush_pend <= flush_pend_next;
        end
    end

    // Refill target is captured at miss start so redirects cannot retarget the write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lat_set <= '0;
            lat_tag <= '0;
            victim  <= '0;
            rr      <= '0;
        end else begin
            if (start_miss) begin
                lat_set <= pc_set;
                lat_tag <= pc_tag;
                victim  <= rr[pc_set];
            end
            if (refill_wr && last_word)
                rr[lat_set] <= (rr[lat_set] == LAST_RR) ? '0 : rr[lat_set] + 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa at default parameters (line = 16 bytes, set stride = 0x800).
module tb_icache_sa;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fetch_able;
    logic [31:0] input_pc;
    logic        hit;
    logic [31:0] hit_ins;
    logic        need_mem;
    logic [31:0] mem_addr;
    logic [31:0] mem_ins;
    logic        mem_ins_ready;

    int          total;
    int          passed;
    logic        h;
    logic [31:0] ins;

    icache_sa dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .fetch_able    (fetch_able),
        .input_pc      (input_pc),
        .hit           (hit),
        .hit_ins       (hit_ins),
        .need_mem      (need_mem),
        .mem_addr      (mem_addr),
        .mem_ins       (mem_ins),
        .mem_ins_ready (mem_ins_ready)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Memory model: each word's content is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    assign mem_ins = mem_word(mem_addr);

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic probe(input logic [31:0] pc, output logic ph, output logic [31:0] pins);
        step();
        fetch_able = 1'b1;
        input_pc   = pc;
        #1;
        ph         = hit;
        pins       = hit_ins;
        fetch_able = 1'b0;
    endtask

    task automatic finish_refill();
        mem_ins_ready = 1'b1;
        repeat (4) step();
        mem_ins_ready = 1'b0;
        fetch_able    = 1'b0;
    endtask

    task automatic fill(input logic [31:0] pc);
        step();
        fetch_able    = 1'b1;
        input_pc      = pc;
        mem_ins_ready = 1'b0;
        step();
        finish_refill();
    endtask

    task automatic test_reset();
        repeat (2) step();
        total++; if (need_mem !== 1'b0) $display("FAIL reset_need_mem: got %b want 0", need_mem); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
        rst_n_in   = 1'b1;
        fetch_able = 1'b1;
        input_pc   = 32'h0;
        #1;
        total++; if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else passed++;
        fetch_able = 1'b0;
    endtask

    task automatic test_cold_miss();
        step();
        fetch_able = 1'b1;
        input_pc   = 32'h100;
        #1;
        total++; if (hit !== 1'b0) $display("FAIL cold_first_hit: got %b want 0", hit); else passed++;
        step();
        mem_ins_ready = 1'b1;
        #1;
        total++; if (need_mem !== 1'b1) $display("FAIL cold_need_mem: got %b want 1", need_mem); else passed++;
        total++; if (mem_addr !== 32'h100) $display("FAIL cold_addr0: got %h want 00000100", mem_addr); else passed++;
        total++; if (hit !== 1'b1 || hit_ins !== mem_word(32'h100))
            $display("FAIL cold_bypass: got hit=%b ins=%h want 1 %h", hit, hit_ins, mem_word(32'h100)); else passed++;
        step();
        total++; if (mem_addr !== 32'h104) $display("FAIL cold_addr1: got %h want 00000104", mem_addr); else passed++;
        total++; if (hit !== 1'b0) $display("FAIL cold_no_bypass: got %b want 0", hit); else passed++;
        step();
        total++; if (mem_addr !== 32'h108) $display("FAIL cold_addr2: got %h want 00000108", mem_addr); else passed++;
        step();
        total++; if (mem_addr !== 32'h10C) $display("FAIL cold_addr3: got %h want 0000010c", mem_addr); else passed++;
        step();
        mem_ins_ready = 1'b0;
        input_pc      = 32'h10C;
        #1;
        total++; if (need_mem !== 1'b0) $display("FAIL cold_done: got need_mem=%b want 0", need_mem); else passed++;
        total++; if (hit !== 1'b1 || hit_ins !== mem_word(32'h10C))
            $display("FAIL cold_hit_10c: got hit=%b ins=%h want 1 %h", hit, hit_ins, mem_word(32'h10C)); else passed++;
        step();
        total++; if (need_mem !== 1'b0) $display("FAIL cold_no_new_req: got %b want 0", need_mem); else passed++;
        input_pc = 32'h100;
        #1;
        total++; if (hit !== 1'b1 || hit_ins !== mem_word(32'h100))
            $display("FAIL cold_hit_100: got hit=%b ins=%h want 1 %h", hit, hit_ins, mem_word(32'h100)); else passed++;
        fetch_able = 1'b0;
    endtask

    task automatic test_redirect();
        step();
        fetch_able    = 1'b1;
        input_pc      = 32'h208;
        mem_ins_ready = 1'b0;
        step();
        mem_ins_ready = 1'b1;
        #1;
        total++; if (mem_addr !== 32'h200) $display("FAIL redir_base: got %h want 00000200", mem_addr); else passed++;
        total++; if (hit !== 1'b0) $display("FAIL redir_no_bypass: got %b want 0", hit); else passed++;
        step();
        input_pc = 32'h300;
        #1;
        total++; if (need_mem !== 1'b1 || mem_addr !== 32'h204)
            $display("FAIL redir_addr1: got need=%b addr=%h want 1 00000204", need_mem, mem_addr); else passed++;
        step();
        fetch_able = 1'b0;
        #1;
        total++; if (need_mem !== 1'b1 || mem_addr !== 32'h208)
            $display("FAIL redir_addr2: got need=%b addr=%h want 1 00000208", need_mem, mem_addr); else passed++;
        step();
        total++; if (mem_addr !== 32'h20C) $display("FAIL redir_addr3: got %h want 0000020c", mem_addr); else passed++;
        step();
        mem_ins_ready = 1'b0;
        #1;
        total++; if (need_mem !== 1'b0) $display("FAIL redir_done: got %b want 0", need_mem); else passed++;
        probe(32'h204, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h204))
            $display("FAIL redir_hit_204: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h204)); else passed++;
        probe(32'h300, h, ins);
        total++; if (h !== 1'b0) $display("FAIL redir_miss_300: got %b want 0", h); else passed++;
        fetch_able = 1'b1;
        step();
        total++; if (need_mem !== 1'b1 || mem_addr !== 32'h300)
            $display("FAIL redir_req_300: got need=%b addr=%h want 1 00000300", need_mem, mem_addr); else passed++;
        finish_refill();
    endtask

    task automatic test_conflict();
        fill(32'h000);
        fill(32'h800);
        probe(32'h000, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h000))
            $display("FAIL conf_hit_000: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h000)); else passed++;
        probe(32'h804, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h804))
            $display("FAIL conf_hit_804: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h804)); else passed++;
        fill(32'h1000);
        probe(32'h008, h, ins);
        total++; if (h !== 1'b0) $display("FAIL conf_evict_000: got hit=%b want 0", h); else passed++;
        probe(32'h800, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h800))
            $display("FAIL conf_keep_800: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h800)); else passed++;
        probe(32'h100C, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h100C))
            $display("FAIL conf_hit_100c: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h100C)); else passed++;
        fill(32'h000);
        probe(32'h800, h, ins);
        total++; if (h !== 1'b0) $display("FAIL conf_evict_800: got hit=%b want 0", h); else passed++;
        probe(32'h1000, h, ins);
        total++; if (h !== 1'b1) $display("FAIL conf_keep_1000: got hit=%b want 1", h); else passed++;
        probe(32'h004, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h004))
            $display("FAIL conf_refill_000: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h004)); else passed++;
    endtask

    task automatic test_flush();
        probe(32'h100, h, ins);
        total++; if (h !== 1'b1) $display("FAIL flush_pre_hit: got %b want 1", h); else passed++;
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        probe(32'h100, h, ins);
        total++; if (h !== 1'b0) $display("FAIL flush_miss_100: got %b want 0", h); else passed++;
        probe(32'h204, h, ins);
        total++; if (h !== 1'b0) $display("FAIL flush_miss_204: got %b want 0", h); else passed++;
        step();
        fetch_able = 1'b1;
        input_pc   = 32'h100;
        step();
        mem_ins_ready = 1'b1;
        step();
        flush_in = 1'b1;
        #1;
        total++; if (need_mem !== 1'b1 || mem_addr !== 32'h104)
            $display("FAIL flush_mid_addr1: got need=%b addr=%h want 1 00000104", need_mem, mem_addr); else passed++;
        step();
        flush_in = 1'b0;
        #1;
        total++; if (need_mem !== 1'b1 || mem_addr !== 32'h108)
            $display("FAIL flush_mid_addr2: got need=%b addr=%h want 1 00000108", need_mem, mem_addr); else passed++;
        step();
        total++; if (need_mem !== 1'b1 || mem_addr !== 32'h10C)
            $display("FAIL flush_mid_addr3: got need=%b addr=%h want 1 0000010c", need_mem, mem_addr); else passed++;
        step();
        mem_ins_ready = 1'b0;
        fetch_able    = 1'b0;
        #1;
        total++; if (need_mem !== 1'b0) $display("FAIL flush_mid_done: got %b want 0", need_mem); else passed++;
        probe(32'h100, h, ins);
        total++; if (h !== 1'b0) $display("FAIL flush_line_invalid: got %b want 0", h); else passed++;
        probe(32'h10C, h, ins);
        total++; if (h !== 1'b0) $display("FAIL flush_line_invalid_10c: got %b want 0", h); else passed++;
        step();
        fetch_able = 1'b1;
        input_pc   = 32'h500;
        flush_in   = 1'b1;
        step();
        flush_in   = 1'b0;
        fetch_able = 1'b0;
        #1;
        total++; if (need_mem !== 1'b0) $display("FAIL flush_priority: got need_mem=%b want 0", need_mem); else passed++;
    endtask

    task automatic test_rdy_stall();
        step();
        fetch_able = 1'b1;
        input_pc   = 32'h400;
        step();
        mem_ins_ready = 1'b1;
        step();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ins_ready = (i % 2 == 0);
            step();
            total++; if (need_mem !== 1'b1 || mem_addr !== 32'h404)
                $display("FAIL stall_hold_%0d: got need=%b addr=%h want 1 00000404", i, need_mem, mem_addr); else passed++;
        end
        rdy_in        = 1'b1;
        mem_ins_ready = 1'b1;
        step();
        total++; if (mem_addr !== 32'h408) $display("FAIL stall_resume1: got %h want 00000408", mem_addr); else passed++;
        step();
        total++; if (mem_addr !== 32'h40C) $display("FAIL stall_resume2: got %h want 0000040c", mem_addr); else passed++;
        step();
        mem_ins_ready = 1'b0;
        fetch_able    = 1'b0;
        #1;
        total++; if (need_mem !== 1'b0) $display("FAIL stall_done: got %b want 0", need_mem); else passed++;
        probe(32'h404, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h404))
            $display("FAIL stall_hit_404: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h404)); else passed++;
        probe(32'h40C, h, ins);
        total++; if (h !== 1'b1 || ins !== mem_word(32'h40C))
            $display("FAIL stall_hit_40c: got hit=%b ins=%h want 1 %h", h, ins, mem_word(32'h40C)); else passed++;
    endtask

    task automatic test_async_reset();
        step();
        fetch_able = 1'b1;
        input_pc   = 32'h600;
        step();
        mem_ins_ready = 1'b1;
        step();
        #2;
        rst_n_in = 1'b0;
        #1;
        total++; if (need_mem !== 1'b0) $display("FAIL areset_need_mem: got %b want 0", need_mem); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL areset_mem_addr: got %h want 0", mem_addr); else passed++;
        mem_ins_ready = 1'b0;
        fetch_able    = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
        probe(32'h404, h, ins);
        total++; if (h !== 1'b0) $display("FAIL areset_inv_404: got %b want 0", h); else passed++;
        probe(32'h1000, h, ins);
        total++; if (h !== 1'b0) $display("FAIL areset_inv_1000: got %b want 0", h); else passed++;
        probe(32'h004, h, ins);
        total++; if (h !== 1'b0) $display("FAIL areset_inv_004: got %b want 0", h); else passed++;
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        flush_in      = 1'b0;
        fetch_able    = 1'b0;
        input_pc      = 32'h0;
        mem_ins_ready = 1'b0;
        test_reset();
        test_cold_miss();
        test_redirect();
        test_conflict();
        test_flush();
        test_rdy_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
